// File: rtl/gpio_uart_pkg.sv
// Shared definitions for the GPIO-fed UART transmitter.
//   uart_state_e         : transmit FSM states
//   UART_FRAME_BITS      : start + 8 data + stop
//   DEFAULT_CLKS_PER_BIT : 50 MHz system clock at 115200 baud
//   frame_cycles()       : clk cycles from one frame start to the next when
//                          frames are sent back to back (one IDLE cycle between)
package gpio_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_FRAME_BITS      = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  function automatic int frame_cycles(input int clks_per_bit);
    return UART_FRAME_BITS * clks_per_bit + 1;
  endfunction

endpackage

// File: rtl/gpio_uart_tx_if.sv
// Write/status bus between the GPIO controller and the UART transmitter.
//   wr_en      : one-cycle write strobe            (master -> slave)
//   wr_data    : byte to transmit                  (master -> slave)
//   clr_ovf    : clears the sticky overflow flag   (master -> slave)
//   full       : FIFO holds FIFO_DEPTH entries     (slave -> master)
//   empty      : FIFO holds no entries             (slave -> master)
//   fifo_count : FIFO occupancy                    (slave -> master)
//   overflow   : sticky, a write was dropped       (slave -> master)
interface gpio_uart_tx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  clr_ovf;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  overflow;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  full, empty, fifo_count, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output full, empty, fifo_count, overflow
  );
endinterface

// File: rtl/gpio_uart_tx_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count flags.
//   clk, reset : clock and synchronous active-high reset
//   push       : write request; ignored while full
//   pop        : read request; ignored while empty
//   wr_data    : data written on an accepted push
//   rd_data    : head entry (combinational read of the read pointer)
//   full/empty : registered occupancy flags after this cycle's push/pop
//   count      : registered occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  logic [CNT_W-1:0]      count_d;

  // full is the registered flag from before this cycle, so a push while full
  // is refused even if a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count_d = count + CNT_W'(do_push) - CNT_W'(do_pop);
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and a resettable array would cost a flop-level clear per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end
endmodule

// File: rtl/gpio_uart_tx.sv
// UART 8N1 transmitter fed by the GPIO write strobe through a small FIFO, so
// CPU stores never wait on the serial line.
//   clk, reset : clock and synchronous active-high reset
//   bus        : gpio_uart_tx_if.slave (wr_en, wr_data, clr_ovf in;
//                full, empty, fifo_count, overflow out)
//   tx         : registered serial output, idles high
//   busy       : registered, high while a frame is in START, DATA or STOP
module gpio_uart_tx
  import gpio_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic           clk,
  input  logic           reset,
  gpio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           busy
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] head;
  logic                  pop;
  logic                  tx_d;
  logic                  bit_done;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (bus.wr_en),
    .pop     (pop),
    .wr_data (bus.wr_data),
    .rd_data (head),
    .full    (bus.full),
    .empty   (bus.empty),
    .count   (bus.fifo_count)
  );

  assign bit_done = (baud_q == BAUD_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!bus.empty) begin
          pop       = 1'b1;
          shift_d   = head;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered, so it is decoded from the state being entered.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx        <= tx_d;
      busy      <= (state_d != IDLE);
      // A new drop takes priority over a same-cycle clear.
      if (bus.wr_en && bus.full) bus.overflow <= 1'b1;
      else if (bus.clr_ovf)      bus.overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gpio_uart_tx.sv
// Directed bench for gpio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Written bytes expected on the line are queued; a serial monitor decodes
// each frame from tx and compares it against the head of the queue.
module tb_gpio_uart_tx;
  import gpio_uart_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = frame_cycles(CPB);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic busy;

  gpio_uart_tx_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  gpio_uart_tx #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  int         starts_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit keep);
    if (keep) exp_q.push_back(b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (!(busy === 1'b0 && bus.empty === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  // Serial receiver: samples each bit in the middle of its CPB-cycle window.
  initial begin
    bit         active;
    int         cnt;
    int         bi;
    logic [7:0] rx;
    active = 1'b0;
    cnt    = 0;
    rx     = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
          starts_q.push_back(cyc);
        end
      end else begin
        cnt++;
        if (cnt >= CPB + 2 && cnt < CPB * 9 && ((cnt - CPB - 2) % CPB) == 0) begin
          bi     = (cnt - CPB - 2) / CPB;
          rx[bi] = tx;
        end
        if (cnt == CPB * 9 + 2) begin
          active = 1'b0;
          check("rx_stop_bit", 32'(tx), 32'd1);
          check("rx_frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] fb;
    int         mx;
    int         n;
    bit         seen_busy;

    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.clr_ovf = 1'b0;
    reset       = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    repeat (8) tick();

    // Single byte 0xA5: latency and exact per-cycle waveform
    fb = {1'b1, 8'hA5, 1'b0};
    write_byte(8'hA5, 1'b1);
    check("t1_empty_n1", 32'(bus.empty), 32'd0);
    check("t1_count_n1", 32'(bus.fifo_count), 32'd1);
    check("t1_busy_n1", 32'(busy), 32'd0);
    check("t1_tx_n1", 32'(tx), 32'd1);
    tick();
    check("t1_busy_n2", 32'(busy), 32'd1);
    check("t1_empty_n2", 32'(bus.empty), 32'd1);
    for (int o = 0; o < 10 * CPB; o++) begin
      check($sformatf("t1_tx_off%0d", o), 32'(tx), 32'(fb[o / CPB]));
      tick();
    end
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_tx_idle", 32'(tx), 32'd1);
    check("t1_all_rx", 32'(exp_q.size()), 32'd0);

    // Burst of three: count peaks at 2, frames spaced FRAME cycles
    starts_q.delete();
    mx = 0;
    for (int i = 1; i <= 3; i++) begin
      write_byte(8'(i), 1'b1);
      if (int'(bus.fifo_count) > mx) mx = int'(bus.fifo_count);
    end
    repeat (6) begin
      tick();
      if (int'(bus.fifo_count) > mx) mx = int'(bus.fifo_count);
    end
    check("t2_count_peak", 32'(mx), 32'd2);
    wait_idle(3 * FRAME + 20, "t2_idle_timeout");
    check("t2_frames", 32'(starts_q.size()), 32'd3);
    if (starts_q.size() == 3) begin
      check("t2_gap01", 32'(starts_q[1] - starts_q[0]), 32'd41);
      check("t2_gap12", 32'(starts_q[2] - starts_q[1]), 32'd41);
    end
    check("t2_all_rx", 32'(exp_q.size()), 32'd0);

    // Overflow: five writes into a 4-deep FIFO while a frame is running
    write_byte(8'h31, 1'b1);
    tick();
    for (int i = 1; i <= 5; i++) write_byte(8'(8'h40 + i), i <= 4);
    check("t3_full", 32'(bus.full), 32'd1);
    check("t3_overflow", 32'(bus.overflow), 32'd1);
    check("t3_count", 32'(bus.fifo_count), 32'd4);
    tick();
    check("t3_overflow_sticky", 32'(bus.overflow), 32'd1);
    pulse_clr();
    check("t3_overflow_clr", 32'(bus.overflow), 32'd0);
    check("t3_full_after_clr", 32'(bus.full), 32'd1);
    wait_idle(6 * FRAME, "t3_idle_timeout");
    check("t3_all_rx", 32'(exp_q.size()), 32'd0);

    // Full FIFO with a write landing in the IDLE (pop) cycle
    write_byte(8'h51, 1'b1);
    for (int i = 1; i <= 4; i++) write_byte(8'(8'h60 + i), 1'b1);
    check("t4_full", 32'(bus.full), 32'd1);
    n = 0;
    while (busy !== 1'b0 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check("t4_reach_idle", 32'(n < 2 * FRAME), 32'd1);
    write_byte(8'h65, 1'b0);
    check("t4_count", 32'(bus.fifo_count), 32'd3);
    check("t4_overflow", 32'(bus.overflow), 32'd1);
    check("t4_full", 32'(bus.full), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    pulse_clr();
    check("t4_overflow_clr", 32'(bus.overflow), 32'd0);
    wait_idle(5 * FRAME + 20, "t4_idle_timeout");
    check("t4_all_rx", 32'(exp_q.size()), 32'd0);

    // Reset during DATA bit 3 with two bytes still queued
    starts_q.delete();
    write_byte(8'h71, 1'b0);
    write_byte(8'h72, 1'b0);
    write_byte(8'h73, 1'b0);
    repeat (15) tick();
    check("t5_pre_busy", 32'(busy), 32'd1);
    check("t5_pre_count", 32'(bus.fifo_count), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_tx", 32'(tx), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_empty", 32'(bus.empty), 32'd1);
    check("t5_count", 32'(bus.fifo_count), 32'd0);
    seen_busy = 1'b0;
    repeat (3 * FRAME) begin
      tick();
      if (busy !== 1'b0 || tx !== 1'b1) seen_busy = 1'b1;
    end
    check("t5_no_more_frames", 32'(seen_busy), 32'd0);
    check("t5_starts", 32'(starts_q.size()), 32'd1);

    // Ten bytes paced every 30 cycles: pointers wrap twice, never full
    mx = 0;
    for (int i = 0; i < 10; i++) begin
      write_byte(8'(8'h10 + i), 1'b1);
      repeat (29) begin
        tick();
        if (int'(bus.fifo_count) > mx) mx = int'(bus.fifo_count);
      end
    end
    check("t6_count_max", 32'(mx <= DEPTH), 32'd1);
    wait_idle(6 * FRAME, "t6_idle_timeout");
    check("t6_overflow", 32'(bus.overflow), 32'd0);
    check("t6_all_rx", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpio_uart_tx.md
Name: gpio_uart_tx

Overview:
- Downstream consumer of the multicycle MIPS GPIO port.
- Accepts the byte strobed out by the GPIO controller when the CPU executes sw to the GPIO address.
- Buffers bytes in a small FIFO and serializes them as UART 8N1 on a single tx pin, so CPU stores never stall on the serial line.

Parameters:
- DATA_WIDTH, 8, byte width; fixed at 8 for 8N1.
- FIFO_DEPTH, 8, entries; power of 2, minimum 2.
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 2.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  one-cycle write strobe from GPIO controller.
- wr_data  input  DATA_WIDTH  byte to transmit, sampled when wr_en=1.
- clr_ovf  input  1  clears the overflow flag.
- tx  output  1  serial line, idle high.
- busy  output  1  1 while a frame is in START, DATA or STOP.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: a write was dropped.

Behaviour:
- Reset is synchronous: at a rising clk with reset=1 the block sets tx=1, busy=0, full=0, empty=1, fifo_count=0, overflow=0.
  - Reset also sets FSM=IDLE, clears the read and write pointers, and zeroes the baud and bit counters.
  - A reset mid-frame aborts the frame immediately; tx returns high on the next cycle and FIFO contents are discarded.
- FIFO write: when wr_en=1 and full=0, wr_data is stored at the write pointer and the pointer increments, wrapping modulo FIFO_DEPTH.
- FIFO write while full: if wr_en=1 and full=1, the byte is dropped and overflow is set to 1 on the next cycle.
  - full is evaluated before any same-cycle pop, so the byte is dropped even if a pop occurs in the same cycle.
- Overflow flag: overflow stays 1 until clr_ovf=1. If clr_ovf and a new overflow occur in the same cycle, set wins.
- Pop: occurs only in IDLE when empty=0. The head byte is loaded into the shift register and the read pointer increments with wrap.
- Simultaneous push and pop when not full: fifo_count is unchanged, and both pointers advance.
- full, empty and fifo_count are registered. They reflect the state after the current cycle's push and pop.
- FSM states and transitions:
  - IDLE: tx=1. If empty=0, pop and go to START. Otherwise stay in IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0], LSB first. Each bit is held for CLKS_PER_BIT cycles, then the register shifts right. After bit_idx=7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Back-to-back frames: because IDLE is revisited, there is exactly one tx=1 IDLE cycle between consecutive frames. The frame period is therefore 10*CLKS_PER_BIT+1 cycles.
- Baud counter: counts from 0 to CLKS_PER_BIT-1, reloads to 0 on each bit boundary, and is held at 0 in IDLE.
- tx and busy are registered outputs.
- Latency, from an empty FIFO in IDLE:
  - wr_en high in cycle N makes the byte visible in the FIFO (empty=0) in cycle N+1.
  - The pop happens in cycle N+1.
  - tx falls in cycle N+2, when busy also rises.
- busy=0 exactly when the FSM is in IDLE.

Decomposition:
- Shared package gpio_uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - UART_FRAME_BITS=10;
  - the default CLKS_PER_BIT constant.
- One sub-module, sync_fifo: DATA_WIDTH and DEPTH parameters; push/pop interface; full, empty and count outputs; synchronous active-high reset on clk/reset.
- The top level contains the FSM, baud counter, shift register and overflow logic.

Test Plan:
(All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4.)
- Single byte:
  - Stimulus: from reset, wr_en=1 with wr_data=0xA5 at cycle 10.
  - Required: tx=0 during cycles 12-15. Data bits follow LSB first: 1,0,1,0,0,1,0,1, four cycles each, during cycles 16-47. tx=1 during cycles 48-51 (stop). busy falls at cycle 52.
- Burst:
  - Stimulus: write 0x01, 0x02, 0x03 on consecutive cycles.
  - Required: fifo_count peaks at 2, because the first byte is popped immediately. Three frames are sent in order. Each frame starts 41 cycles after the previous one starts.
- Overflow:
  - Stimulus: while a frame is in progress, write 5 bytes into a 4-deep FIFO.
  - Required: the fifth byte is dropped, full=1 and overflow=1. Pulsing clr_ovf returns overflow to 0. Only the first 4 bytes are transmitted.
- Full with simultaneous pop:
  - Stimulus: FIFO full and the FSM entering IDLE in the same cycle that wr_en=1.
  - Required: the written byte is dropped, overflow=1, and fifo_count=3 next cycle.
- Reset mid-frame:
  - Stimulus: assert reset for 1 cycle during DATA bit 3, with 2 bytes still queued.
  - Required: next cycle tx=1, busy=0, empty=1, fifo_count=0. No further frames are sent.
- Pointer wrap:
  - Stimulus: stream 10 bytes (0x10 to 0x19), keeping fifo_count at or below 4.
  - Required: all 10 bytes are received in order with overflow=0, confirming the pointers wrap twice correctly.
